uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that samples an asynchronous 8N1 line, recovers bytes LSB-first and presents each byte with a one-cycle strobe. It is the receive counterpart of `uart_tx` and shares its `BAUD`/`F` parameterisation, so a `uart_tx` → `uart_rx` loopback on the same clock is the standard integration and test configuration. The block feeds downstream byte consumers (decoders, FIFOs) in the FPGA experiment designs.

## Interface
- `BAUD`, 115200, line bit rate in bit/s.
- `F`, 50000000, `clk` frequency in Hz.
- Derived, local, not overridable:
  - `CPB = F / BAUD`, integer floor; 434 at defaults.
  - `HALF = CPB / 2`, floor; 217 at defaults.
  - `CPB < 4` is a configuration error; the implementation must flag it at elaboration.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset. **One clock; reset is synchronous and active-high.**
- `rx`  in  1  asynchronous serial line; idle high.
- `data`  out  8  last correctly framed byte; holds its value between frames.
- `valid`  out  1  one-cycle strobe; `data` is new in this cycle.
- `frame_err`  out  1  one-cycle strobe; stop bit sampled low.
- `busy`  out  1  high from start-edge detection until return to IDLE.

## Operation
- Input conditioning:
  - `rx` passes through a 2-flop synchronizer, then a third flop used for edge detection.
  - All three flops reset to 1.
  - Only the synchronized value is used downstream.
- States: IDLE, START, DATA, STOP, BREAK.
- Bit-timing counter:
  - Width is `ceil(log2(CPB))`.
  - Cleared on every state entry and on every bit sample.
- Bit index: 3 bits, counting 0..7.
- Shift register: 8 bits, filled LSB first (first data bit lands in bit 0).
- IDLE:
  - `busy` = 0.
  - A falling edge on the synchronized line (previous 1, current 0) moves to START and sets `busy` = 1.
- START:
  - Count `HALF` cycles, then sample.
  - Sample 0: go to DATA.
  - Sample 1: glitch or false start. Return to IDLE; no strobe, `data` unchanged.
- DATA:
  - Sample every `CPB` cycles.
  - Shift the sample into bit index *k*, with *k* running 0..7.
  - After the 8th sample, go to STOP.
- STOP: sample after `CPB` cycles.
  - Sample 1: load the shift register into `data`, pulse `valid`, go to IDLE.
  - Sample 0: pulse `frame_err`, leave `data` unchanged, go to BREAK.
- BREAK: wait until the synchronized line is 1, then go to IDLE. This prevents a held-low line (break) from retriggering.
- Reset:
  - State IDLE; counter and bit index 0.
  - `data` = 0x00; `valid`, `frame_err`, `busy` = 0; shift register 0.
  - Reset mid-frame aborts the frame with no strobe. The next frame is accepted only after a new falling edge.
- No ASCII conversion: `data` is the raw line byte. The `+48` applied by `uart_tx` arrives as-is; e.g. input 5 is received as 0x35.
- `valid` and `frame_err` are never high in the same cycle.

## Timing
- T0 is the cycle in which IDLE detects the falling edge. T0 occurs 3 clocks after the `rx` transition (two synchronizer flops plus the edge flop).
- Sample instants:
  - Start bit: T0 + `HALF`.
  - Data bit *k*: T0 + `HALF` + (k+1)·`CPB`.
  - Stop bit: T0 + `HALF` + 9·`CPB`.
- On the stop-sample edge, `data`/`valid` (or `frame_err`) are registered. They are visible for exactly one cycle, and the state is IDLE in that same cycle.
- At defaults, the stop sample is at T0 + 4123.
- Back-to-back frames: a start edge immediately following the stop bit is accepted. Minimum inter-frame gap is 0 bit times.
- `busy` falls in the strobe cycle, except after a framing error, when it stays high through BREAK.
- Tolerated baud mismatch: ±4 % (mid-bit sampling).

## Test plan
- Reset: hold `rst` 5 cycles with `rx` = 0 → `data` = 0x00, `valid` = `frame_err` = `busy` = 0, and no start detected while `rx` stays low after release.
- Loopback from `uart_tx` with `data` = 5 → exactly one `valid` pulse with `data` = 0x35; `valid` rises T0 + 4123 cycles after `busy` rises.
- Direct 8N1 stimulus 0xA5, then 0x3C with zero gap → two `valid` pulses 10·434 cycles apart, carrying 0xA5 then 0x3C.
- Glitch: `rx` low for 100 cycles, then high → START aborts at the start sample, no strobe, back in IDLE, `data` unchanged.
- Framing error: 0x55 sent with stop bit 0, line held low 3000 cycles, then high → one `frame_err` pulse, no `valid`, `data` keeps its prior value, `busy` stays 1 until the line goes high; a following good 0x12 → `valid` with 0x12.
- Reset mid-frame: assert `rst` during data bit 3 of 0xFF, release, then send 0x81 → no strobe for the aborted frame, one `valid` with 0x81.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte bundle between uart_rx and its byte consumer
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (output data, output valid, output frame_err, output busy);
  modport slave  (input  data, input  valid, input  frame_err, input  busy);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit sampling and framing-error detection
module uart_rx #(
  parameter int BAUD = 115200,
  parameter int F    = 50000000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int CPB   = F / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CPB - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  generate
    if (CPB < 4) begin : g_cfg_err
      $error("uart_rx: F / BAUD must be at least 4 clocks per bit");
    end
  endgenerate

  logic             sync1, sync2, sync3;
  logic [1:0]       flush;
  logic             armed;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic [7:0]       data_q;
  logic             valid_q, frame_err_q, busy_q;
  logic             fall;

  // A start edge is only trusted once the line has been seen high after the
  // synchronizer has flushed its reset value, so a line held low through reset
  // never looks like a start bit.
  assign fall = armed && sync3 && !sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      sync3       <= 1'b1;
      flush       <= 2'd0;
      armed       <= 1'b0;
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      shreg       <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1       <= rx;
      sync2       <= sync1;
      sync3       <= sync2;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      if (flush != 2'd2) flush <= flush + 2'd1;
      if (flush == 2'd2 && sync2) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          if (fall) begin
            state  <= S_START;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            idx <= 3'd0;
            if (!sync2) begin
              state <= S_DATA;
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == BIT_END) begin
            cnt        <= '0;
            shreg[idx] <= sync2;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (sync2) begin
              data_q  <= shreg;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state   <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (sync2) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed 8N1 stimulus against a frame-level event/window model of uart_rx
module tb_uart_rx;

  localparam int BAUD = 115200;
  localparam int F    = 50000000;
  localparam int CPB  = F / BAUD;
  localparam int HALF = CPB / 2;
  localparam int BIG  = 32'h7fffffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b0;

  uart_rx_if bus ();

  uart_rx #(.BAUD(BAUD), .F(F)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected strobes (cycle, kind, byte) and expected busy intervals [lo, hi).
  int         ev_t[$];
  bit         ev_err[$];
  logic [7:0] ev_d[$];
  int         win_lo[$];
  int         win_hi[$];

  logic [7:0] model_data = 8'h00;
  bit         exp_v, exp_fe, exp_busy;

  int         valid_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] got_d[$];
  int         valid_cyc[$];
  int         busy_rise = 0;
  logic       busy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_data = 8'h00;
      ev_t.delete();
      ev_err.delete();
      ev_d.delete();
      win_lo.delete();
      win_hi.delete();
      busy_prev = 1'b0;
    end else begin
      exp_v  = 1'b0;
      exp_fe = 1'b0;
      if (ev_t.size() > 0 && ev_t[0] == cyc) begin
        if (ev_err[0]) exp_fe = 1'b1;
        else begin
          exp_v      = 1'b1;
          model_data = ev_d[0];
        end
        void'(ev_t.pop_front());
        void'(ev_err.pop_front());
        void'(ev_d.pop_front());
      end
      exp_busy = 1'b0;
      foreach (win_lo[i])
        if (cyc >= win_lo[i] && cyc < win_hi[i]) exp_busy = 1'b1;

      chk("valid", bus.valid, exp_v);
      chk("frame_err", bus.frame_err, exp_fe);
      chk("busy", bus.busy, exp_busy);
      chk("data", bus.data, model_data);

      if (bus.valid) begin
        valid_cnt++;
        got_d.push_back(bus.data);
        valid_cyc.push_back(cyc);
      end
      if (bus.frame_err) fe_cnt++;
      if (bus.busy && !busy_prev) busy_rise = cyc;
      busy_prev = bus.busy;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; the start edge reaches the receiver FSM three clocks later.
  task automatic send(input logic [7:0] b, input logic stop);
    int s;
    rx = 1'b0;
    s  = cyc;
    win_lo.push_back(s + 3);
    win_hi.push_back(stop ? s + 3 + HALF + 9 * CPB : BIG);
    ev_t.push_back(s + 3 + HALF + 9 * CPB);
    ev_err.push_back(!stop);
    ev_d.push_back(b);
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(CPB);
    end
    rx = stop;
    hold(CPB);
    if (stop) rx = 1'b1;
  endtask

  initial begin
    int s;
    int h;

    // Reset with the line held low; no start may be seen after release.
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_data", bus.data, 8'h00);
    chk("reset_valid", bus.valid, 1'b0);
    chk("reset_frame_err", bus.frame_err, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    hold(1000);
    chk("reset_low_busy", bus.busy, 1'b0);
    chk("reset_low_strobes", valid_cnt + fe_cnt, 0);
    rx = 1'b1;
    hold(50);

    // Loopback byte as uart_tx would send it for input 5.
    send(8'(5 + 48), 1'b1);
    hold(20);
    chk("loop_count", valid_cnt, 1);
    chk("loop_data", got_d[0], 8'h35);
    chk("loop_latency", valid_cyc[0] - busy_rise, 4123);

    // Back-to-back frames with zero gap.
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    hold(20);
    chk("b2b_count", valid_cnt, 3);
    chk("b2b_first", got_d[1], 8'hA5);
    chk("b2b_second", got_d[2], 8'h3C);
    chk("b2b_spacing", valid_cyc[2] - valid_cyc[1], 4340);

    // Short low glitch: aborted at the start sample.
    rx = 1'b0;
    s  = cyc;
    win_lo.push_back(s + 3);
    win_hi.push_back(s + 3 + HALF);
    hold(100);
    rx = 1'b1;
    hold(400);
    chk("glitch_count", valid_cnt, 3);
    chk("glitch_busy", bus.busy, 1'b0);
    chk("glitch_data", bus.data, 8'h3C);

    // Framing error followed by a held-low break, then a good frame.
    send(8'h55, 1'b0);
    hold(3000 - CPB);
    chk("break_busy", bus.busy, 1'b1);
    rx = 1'b1;
    h  = cyc;
    win_hi[win_hi.size() - 1] = h + 3;
    hold(20);
    chk("ferr_count", fe_cnt, 1);
    chk("ferr_no_valid", valid_cnt, 3);
    chk("ferr_data", bus.data, 8'h3C);
    chk("ferr_busy_after", bus.busy, 1'b0);
    send(8'h12, 1'b1);
    hold(20);
    chk("after_ferr_count", valid_cnt, 4);
    chk("after_ferr_data", got_d[3], 8'h12);

    // Reset during data bit 3 of 0xFF, then a fresh frame.
    rx = 1'b0;
    s  = cyc;
    win_lo.push_back(s + 3);
    win_hi.push_back(BIG);
    hold(CPB);
    rx = 1'b1;
    hold(3 * CPB + CPB / 2);
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    hold(6 * CPB);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_count", valid_cnt, 4);
    chk("midrst_data", bus.data, 8'h00);
    send(8'h81, 1'b1);
    hold(20);
    chk("midrst_next_count", valid_cnt, 5);
    chk("midrst_next_data", got_d[4], 8'h81);
    chk("midrst_next_port", bus.data, 8'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
